// File: rtl/fb_pkg.sv
// Shared constants for the framebuffer read responder: default geometry,
// pixel base address, response FIFO depth and the index-width helper.
package fb_pkg;

   localparam int          RAM_WIDTH       = 24;
   localparam int          RAM_DEPTH       = 786432;
   localparam int          RAM_ADDR_BITS   = 32;
   localparam logic [31:0] FB_BASE         = 32'h9000_0000;
   localparam int          RESP_FIFO_DEPTH = 3;

   // Smallest w with 2**w >= n; used for the pixel index width.
   function automatic int fb_log2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   localparam int IDX_W = fb_log2(RAM_DEPTH);
   localparam int CNT_W = fb_log2(RESP_FIFO_DEPTH + 1);

endpackage

// File: rtl/fb_resp_fifo.sv
// Three-entry ordered response FIFO; head data is presented combinationally
// from storage, count reports occupancy after the last clock edge.
module fb_resp_fifo
   import fb_pkg::*;
#(
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] store [RESP_FIFO_DEPTH];
   logic [CNT_W-1:0]  rptr;
   logic [CNT_W-1:0]  wptr;

   function automatic logic [CNT_W-1:0] ptr_next(input logic [CNT_W-1:0] p);
      return (p == CNT_W'(RESP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= ptr_next(wptr);
         if (pop)  rptr <= ptr_next(rptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) store[wptr] <= push_data;
   end

   assign head = store[rptr];

endmodule

// File: rtl/framebuffer_responder.sv
// Framebuffer pixel read responder with a write port; optional per-byte write
// enables are compiled in with FB_BYTE_WE_EN.
module framebuffer_responder #(
   parameter int                       RAM_WIDTH     = fb_pkg::RAM_WIDTH,
   parameter int                       RAM_DEPTH     = fb_pkg::RAM_DEPTH,
   parameter int                       RAM_ADDR_BITS = fb_pkg::RAM_ADDR_BITS,
   parameter logic [RAM_ADDR_BITS-1:0] FB_BASE       = fb_pkg::FB_BASE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [RAM_ADDR_BITS-1:0] rd_addr,
   input  logic                     rd_addr_valid,
   output logic                     rd_addr_rdy,
   output logic [RAM_WIDTH-1:0]     rd_data,
   output logic                     rd_data_valid,
   input  logic                     rd_data_rdy,
   input  logic                     wr_en,
   input  logic [RAM_ADDR_BITS-1:0] wr_addr,
   input  logic [RAM_WIDTH-1:0]     wr_data
`ifdef FB_BYTE_WE_EN
   ,
   input  logic [2:0]               wr_be
`endif
);

   localparam int IDX_W = fb_pkg::fb_log2(RAM_DEPTH);
   localparam int CNT_W = fb_pkg::CNT_W;

   logic [RAM_ADDR_BITS-1:0] rd_off;
   logic [RAM_ADDR_BITS-1:0] wr_off;
   logic                     rd_in_range;
   logic                     wr_in_range;
   logic [IDX_W-1:0]         rd_idx;
   logic [IDX_W-1:0]         wr_idx;

   assign rd_off      = rd_addr - FB_BASE;
   assign wr_off      = wr_addr - FB_BASE;
   assign rd_in_range = (rd_addr >= FB_BASE) && (rd_off < RAM_ADDR_BITS'(RAM_DEPTH));
   assign wr_in_range = (wr_addr >= FB_BASE) && (wr_off < RAM_ADDR_BITS'(RAM_DEPTH));
   assign rd_idx      = rd_off[IDX_W-1:0];
   assign wr_idx      = wr_off[IDX_W-1:0];

   logic                 accept;
   logic                 wr_go;
   logic                 s1_valid;
   logic                 s1_oor;
   logic [RAM_WIDTH-1:0] ram_q;
   logic [RAM_WIDTH-1:0] pixels [RAM_DEPTH];

   assign accept = rd_addr_valid && rd_addr_rdy;
   assign wr_go  = wr_en && !rst && wr_in_range;

   // One pipeline stage covers the RAM read; out-of-range reads bypass the RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_oor   <= 1'b0;
      end else begin
         s1_valid <= accept;
         s1_oor   <= !rd_in_range;
      end
   end

   // Read-first: the read samples the array before this edge's write lands.
   always_ff @(posedge clk) begin
      if (accept && rd_in_range) ram_q <= pixels[rd_idx];
      if (wr_go) begin
`ifdef FB_BYTE_WE_EN
         for (int i = 0; i < RAM_WIDTH / 8; i++) begin
            if (wr_be[i]) pixels[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
`else
         pixels[wr_idx] <= wr_data;
`endif
      end
   end

   logic                 fifo_push;
   logic                 fifo_pop;
   logic [RAM_WIDTH-1:0] fifo_head;
   logic [CNT_W-1:0]     fifo_count;
   logic [CNT_W:0]       occupancy;

   assign fifo_push = s1_valid;
   assign fifo_pop  = rd_data_valid && rd_data_rdy;

   fb_resp_fifo #(
      .DATA_W (RAM_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (s1_oor ? '0 : ram_q),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   // An entry leaving this cycle frees its slot for a request in the same cycle.
   assign occupancy     = {1'b0, fifo_count} - (CNT_W + 1)'(fifo_pop) + (CNT_W + 1)'(s1_valid);
   assign rd_addr_rdy   = !rst && (occupancy < (CNT_W + 1)'(fb_pkg::RESP_FIFO_DEPTH));
   assign rd_data_valid = !rst && (fifo_count != '0);
   assign rd_data       = rd_data_valid ? fifo_head : '0;

endmodule

// File: tb/tb_framebuffer_responder.sv
// Directed bench for framebuffer_responder; handles builds with and without
// FB_BYTE_WE_EN.
module tb_framebuffer_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] rd_addr = '0;
   logic        rd_addr_valid = 1'b0;
   logic        rd_addr_rdy;
   logic [23:0] rd_data;
   logic        rd_data_valid;
   logic        rd_data_rdy = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [23:0] wr_data = '0;
`ifdef FB_BYTE_WE_EN
   logic [2:0]  wr_be = 3'b111;
`endif

   localparam logic [31:0] BASE = 32'h9000_0000;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] exp_q[$];
   int          acc_cyc_q[$];
   int          pop_cyc_q[$];

   framebuffer_responder dut (
      .clk           (clk),
      .rst           (rst),
      .rd_addr       (rd_addr),
      .rd_addr_valid (rd_addr_valid),
      .rd_addr_rdy   (rd_addr_rdy),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .rd_data_rdy   (rd_data_rdy),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data)
`ifdef FB_BYTE_WE_EN
      ,
      .wr_be         (wr_be)
`endif
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // scoreboard: every popped response must match the oldest expectation
   always @(negedge clk) begin
      if (rd_data_valid && rd_data_rdy) begin
         pop_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) check("unexpected_rsp", 32'(rd_data), 32'hDEAD);
         else                   check("rd_data", 32'(rd_data), exp_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_pix(input logic [31:0] a, input logic [23:0] d);
      wr_addr = a;
      wr_data = d;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic rd_req(input logic [31:0] a, input logic [23:0] e);
      int  t;
      bit  done;
      t    = 0;
      done = 1'b0;
      rd_addr       = a;
      rd_addr_valid = 1'b1;
      while (!done && t < 50) begin
         @(negedge clk);
         if (rd_addr_rdy) begin
            done = 1'b1;
            exp_q.push_back(32'(e));
            acc_cyc_q.push_back(cyc);
         end
         step();
         t++;
      end
      if (!done) check("rd_req_timeout", 32'(done), 32'd1);
      rd_addr_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      rd_data_rdy = 1'b1;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      step();
   endtask

   task automatic clear_hist();
      acc_cyc_q.delete();
      pop_cyc_q.delete();
   endtask

   initial begin
      // reset
      rst = 1'b1;
      repeat (2) step();
      @(negedge clk);
      check("rst_valid", 32'(rd_data_valid), 32'd0);
      check("rst_data", 32'(rd_data), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_rdy", 32'(rd_addr_rdy), 32'd1);
      check("post_rst_valid", 32'(rd_data_valid), 32'd0);
      step();

      // preload
      wr_pix(BASE + 0, 24'h000011);
      wr_pix(BASE + 1, 24'h000022);
      wr_pix(BASE + 2, 24'h000033);
      wr_pix(BASE + 3, 24'h000044);
      wr_pix(BASE + 5, 24'h123456);
      wr_pix(32'h900B_FFFF, 24'h5A5A5A);

      // back-to-back stream: first response at N+2, then one per cycle
      clear_hist();
      rd_req(BASE + 0, 24'h000011);
      rd_req(BASE + 1, 24'h000022);
      rd_req(BASE + 2, 24'h000033);
      rd_req(BASE + 3, 24'h000044);
      drain();
      check("b2b_n_pops", 32'(pop_cyc_q.size()), 32'd4);
      if (pop_cyc_q.size() == 4 && acc_cyc_q.size() == 4) begin
         check("b2b_first_lat", 32'(pop_cyc_q[0] - acc_cyc_q[0]), 32'd2);
         for (int i = 1; i < 4; i++) begin
            check("b2b_acc_gap", 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'd1);
            check("b2b_pop_gap", 32'(pop_cyc_q[i] - pop_cyc_q[i-1]), 32'd1);
         end
      end

      // back-pressure: three outstanding, then rd_addr_rdy must drop
      rd_data_rdy = 1'b0;
      rd_req(BASE + 0, 24'h000011);
      rd_req(BASE + 1, 24'h000022);
      rd_req(BASE + 2, 24'h000033);
      rd_addr       = BASE + 3;
      rd_addr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_addr_rdy", 32'(rd_addr_rdy), 32'd0);
         check("bp_valid", 32'(rd_data_valid), 32'd1);
         check("bp_data_hold", 32'(rd_data), 32'h000011);
         step();
      end
      rd_data_rdy = 1'b1;
      rd_req(BASE + 3, 24'h000044);
      drain();

      // out-of-range reads and writes
      wr_pix(32'h8FFF_FFFF, 24'h777777);
      wr_pix(32'h900C_0000, 24'h888888);
      rd_req(BASE + 1, 24'h000022);
      rd_req(32'h8FFF_FFFF, 24'h000000);
      rd_req(BASE + 2, 24'h000033);
      rd_req(32'h900C_0000, 24'h000000);
      rd_req(32'h900B_FFFF, 24'h5A5A5A);
      rd_req(BASE + 0, 24'h000011);
      drain();

      // read/write collision on index 5 returns old contents
      wr_addr = BASE + 5;
      wr_data = 24'hABCDEF;
      wr_en   = 1'b1;
      rd_req(BASE + 5, 24'h123456);
      wr_en   = 1'b0;
      rd_req(BASE + 5, 24'hABCDEF);
      drain();

      // reset with three responses outstanding
      rd_data_rdy = 1'b0;
      rd_req(BASE + 0, 24'h000011);
      rd_req(BASE + 1, 24'h000022);
      rd_req(BASE + 2, 24'h000033);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 32'(rd_data_valid), 32'd0);
      check("mid_rst_data", 32'(rd_data), 32'd0);
      step();
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("after_rst_valid", 32'(rd_data_valid), 32'd0);
      check("after_rst_rdy", 32'(rd_addr_rdy), 32'd1);
      step();
      rd_data_rdy = 1'b1;
      repeat (3) step();
      rd_req(BASE + 2, 24'h000033);
      rd_req(BASE + 5, 24'hABCDEF);
      drain();

      // partial-pixel write
`ifdef FB_BYTE_WE_EN
      wr_be = 3'b111;
      wr_pix(BASE + 7, 24'hFFFFFF);
      wr_be = 3'b010;
      wr_pix(BASE + 7, 24'h000000);
      wr_be = 3'b111;
      rd_req(BASE + 7, 24'hFF00FF);
`else
      wr_pix(BASE + 7, 24'hFFFFFF);
      wr_pix(BASE + 7, 24'h000000);
      rd_req(BASE + 7, 24'h000000);
`endif
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
